// File: rtl/alu_pkg.sv
// Shared ALU opcodes, sequencer op codes and sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLTU = 3'b101;

    localparam logic [1:0] SEQ_MUL  = 2'b00;
    localparam logic [1:0] SEQ_DIVU = 2'b01;
    localparam logic [1:0] SEQ_REMU = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_ITER = 3'd1,
        ST_DIV_CMP  = 3'd2,
        ST_DIV_SUB  = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// Shared single-cycle ALU; unsupported selects produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        unique case (sel)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle MUL/DIVU/REMU sequencer that time-shares the core ALU:
// shift-add multiply and restoring divide, one ALU operation per cycle.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_sel,
    input  logic [XLEN-1:0] alu_result,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    seq_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_sh_q, rem_sh_d;
    logic            ge_q, ge_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] rem_sh;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        dvd_d    = dvd_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        rem_sh_d = rem_sh_q;
        ge_d     = ge_q;
        result_d = result_q;
        rem_sh   = '0;
        alu_a    = '0;
        alu_b    = '0;
        alu_sel  = ALU_ADD;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op;
                    mcand_d  = opa;
                    mplier_d = opb;
                    dvd_d    = opa;
                    dvsr_d   = opb;
                    acc_d    = '0;
                    rem_d    = '0;
                    quo_d    = '0;
                    cnt_d    = '0;
                    if (op == SEQ_DIVU || op == SEQ_REMU)
                        state_d = ST_DIV_CMP;
                    else
                        state_d = ST_MUL_ITER;
                end
            end
            ST_MUL_ITER: begin
                alu_a   = acc_q;
                alu_b   = mcand_q;
                alu_sel = ALU_ADD;
                if (mplier_q[0])
                    acc_d = alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Result is captured on the way into DONE so it is valid with done
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = acc_d;
                end
            end
            ST_DIV_CMP: begin
                rem_sh   = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
                alu_a    = rem_sh;
                alu_b    = dvsr_q;
                alu_sel  = ALU_SLTU;
                ge_d     = (alu_result == '0);
                rem_sh_d = rem_sh;
                dvd_d    = dvd_q << 1;
                state_d  = ST_DIV_SUB;
            end
            ST_DIV_SUB: begin
                alu_a   = rem_sh_q;
                alu_b   = dvsr_q;
                alu_sel = ALU_SUB;
                if (ge_q) begin
                    rem_d = alu_result;
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh_q;
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = (op_q == SEQ_REMU) ? rem_d : quo_d;
                end else begin
                    state_d = ST_DIV_CMP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            dvd_q    <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            rem_sh_q <= '0;
            ge_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            dvd_q    <= dvd_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            rem_sh_q <= rem_sh_d;
            ge_q     <= ge_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_MUL_ITER) ||
                    (state_q == ST_DIV_CMP)  ||
                    (state_q == ST_DIV_SUB);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule
